// File: rtl/rr_arb_mux_4_1_if.sv
// rtl/rr_arb_mux_4_1_if.sv - four-producer valid/ready bundle plus the single output stream
interface rr_arb_mux_4_1_if #(
   parameter int WIDTH = 4
);
   logic [3:0]       in_valid;
   logic [WIDTH-1:0] in_data0;
   logic [WIDTH-1:0] in_data1;
   logic [WIDTH-1:0] in_data2;
   logic [WIDTH-1:0] in_data3;
   logic [3:0]       in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_sel;

   modport master (
      output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_arb_mux_4_1.sv
// rtl/rr_arb_mux_4_1.sv - round-robin arbiter over four channels with one registered output stage
module rr_arb_mux_4_1 #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   rr_arb_mux_4_1_if.slave    bus
);
   logic [1:0]       r_last_grant;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [1:0]       r_out_sel;

   logic             w_load;
   logic             w_any;
   logic [1:0]       w_idx;
   logic [1:0]       w_win_idx;
   logic [3:0]       w_grant;
   logic [WIDTH-1:0] w_win_data;

   // Output register frees up when empty or when its word drains this cycle.
   assign w_load = !r_out_valid || bus.out_ready;

   // Scan from the channel after the last winner; 2-bit wrap gives the mod-4 order.
   always_comb begin
      w_grant   = 4'b0000;
      w_win_idx = r_last_grant;
      w_any     = 1'b0;
      w_idx     = r_last_grant;
      for (int k = 1; k <= 4; k++) begin
         w_idx = r_last_grant + 2'(k);
         if (!w_any && bus.in_valid[w_idx]) begin
            w_any          = 1'b1;
            w_win_idx      = w_idx;
            w_grant[w_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      w_win_data = bus.in_data0;
      case (w_win_idx)
         2'd0:    w_win_data = bus.in_data0;
         2'd1:    w_win_data = bus.in_data1;
         2'd2:    w_win_data = bus.in_data2;
         default: w_win_data = bus.in_data3;
      endcase
   end

   assign bus.in_ready = {4{w_load}} & w_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_sel    <= 2'd0;
         r_last_grant <= 2'd3;
      end else if (w_load) begin
         if (w_any) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_win_data;
            r_out_sel    <= w_win_idx;
            r_last_grant <= w_win_idx;
         end else begin
            r_out_valid  <= 1'b0;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_sel   = r_out_sel;
endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// tb/tb_rr_arb_mux_4_1.sv - self-checking bench for rr_arb_mux_4_1
module tb_rr_arb_mux_4_1;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   rr_arb_mux_4_1_if #(.WIDTH(4)) bus ();

   rr_arb_mux_4_1 #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a register slot plus the index of the last channel that won.
   int         m_last;
   bit         m_valid;
   logic [3:0] m_data;
   int         m_sel;

   function automatic int pick(input logic [3:0] v, input int last);
      for (int k = 1; k <= 4; k++)
         if (v[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] data_of(input int c);
      case (c)
         0:       return bus.in_data0;
         1:       return bus.in_data1;
         2:       return bus.in_data2;
         default: return bus.in_data3;
      endcase
   endfunction

   function automatic logic [3:0] exp_ready();
      int w;
      w = pick(bus.in_valid, m_last);
      if ((!m_valid || bus.out_ready) && w >= 0) return 4'(1 << w);
      return 4'b0000;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= 4'h0;
         m_sel   <= 0;
         m_last  <= 3;
      end else if (!m_valid || bus.out_ready) begin
         if (pick(bus.in_valid, m_last) < 0) begin
            m_valid <= 1'b0;
         end else begin
            m_valid <= 1'b1;
            m_data  <= data_of(pick(bus.in_valid, m_last));
            m_sel   <= pick(bus.in_valid, m_last);
            m_last  <= pick(bus.in_valid, m_last);
         end
      end
   end

   // Per-cycle comparison, 3 time units after the falling edge where inputs change.
   always @(negedge clk) begin
      #3;
      chk("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("model_in_ready",  32'(bus.in_ready),  32'(exp_ready()));
      chk("model_out_data",  32'(bus.out_data),  32'(m_data));
      chk("model_out_sel",   32'(bus.out_sel),   32'(m_sel));
   end

   // Apply inputs on the falling edge, return at the check point of that cycle.
   task automatic drive(input logic [3:0] v, input logic rdy);
      @(negedge clk);
      bus.in_valid  = v;
      bus.out_ready = rdy;
      #3;
   endtask

   logic [3:0] seq_data [5];

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 4'b0000;
      bus.out_ready = 1'b0;
      bus.in_data0  = 4'hA;
      bus.in_data1  = 4'hB;
      bus.in_data2  = 4'hC;
      bus.in_data3  = 4'hD;
      seq_data[0] = 4'hA; seq_data[1] = 4'hB; seq_data[2] = 4'hC;
      seq_data[3] = 4'hD; seq_data[4] = 4'hA;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_out_data",  32'(bus.out_data),  32'd0);
      chk("reset_out_sel",   32'(bus.out_sel),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // All four valid: rotating 0,1,2,3,0
      drive(4'b1111, 1'b1);
      chk("rr_first_ready", 32'(bus.in_ready), 32'b0001);
      for (int i = 0; i < 5; i++) begin
         drive(4'b1111, 1'b1);
         chk("rr_sel",   32'(bus.out_sel),   32'(i % 4));
         chk("rr_data",  32'(bus.out_data),  32'(seq_data[i]));
         chk("rr_valid", 32'(bus.out_valid), 32'd1);
      end

      // Channel 2 alone
      bus.in_data2 = 4'h5;
      drive(4'b0100, 1'b1);
      chk("solo_ready", 32'(bus.in_ready), 32'b0100);
      for (int i = 0; i < 3; i++) begin
         drive(4'b0100, 1'b1);
         chk("solo_ready", 32'(bus.in_ready), 32'b0100);
         chk("solo_data",  32'(bus.out_data), 32'h5);
         chk("solo_sel",   32'(bus.out_sel),  32'd2);
      end

      // Backpressure with channel 1 holding 9
      bus.in_data1 = 4'h9;
      bus.in_data2 = 4'hC;
      drive(4'b0010, 1'b1);
      chk("bp_load_ready", 32'(bus.in_ready), 32'b0010);
      for (int i = 0; i < 3; i++) begin
         drive(4'b1111, 1'b0);
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_data",  32'(bus.out_data),  32'h9);
         chk("bp_sel",   32'(bus.out_sel),   32'd1);
         chk("bp_ready", 32'(bus.in_ready),  32'b0000);
      end
      drive(4'b1111, 1'b1);
      chk("bp_release_ready", 32'(bus.in_ready), 32'b0100);
      drive(4'b0000, 1'b1);
      chk("bp_next_data", 32'(bus.out_data), 32'hC);
      chk("bp_next_sel",  32'(bus.out_sel),  32'd2);

      // Gap fairness: channels 0 and 3 after last winner 0
      drive(4'b0001, 1'b1);
      chk("gap_seed_ready", 32'(bus.in_ready), 32'b0001);
      drive(4'b1001, 1'b1);
      chk("gap_ready0", 32'(bus.in_ready), 32'b1000);
      drive(4'b1001, 1'b1);
      chk("gap_ready1", 32'(bus.in_ready), 32'b0001);
      drive(4'b1001, 1'b1);
      chk("gap_ready2", 32'(bus.in_ready), 32'b1000);
      drive(4'b1001, 1'b1);
      chk("gap_ready3", 32'(bus.in_ready), 32'b0001);

      // Empty after a channel 3 word
      drive(4'b1000, 1'b1);
      chk("empty_load_ready", 32'(bus.in_ready), 32'b1000);
      drive(4'b0000, 1'b1);
      chk("empty_word_valid", 32'(bus.out_valid), 32'd1);
      drive(4'b0000, 1'b1);
      chk("empty_valid", 32'(bus.out_valid), 32'd0);
      chk("empty_data",  32'(bus.out_data),  32'hD);
      chk("empty_sel",   32'(bus.out_sel),   32'd3);

      // Reset while stalled on a held word
      drive(4'b0100, 1'b1);
      drive(4'b0000, 1'b0);
      chk("mid_held_valid", 32'(bus.out_valid), 32'd1);
      chk("mid_held_sel",   32'(bus.out_sel),   32'd2);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_data",  32'(bus.out_data),  32'd0);
      chk("mid_rst_sel",   32'(bus.out_sel),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_valid  = 4'b1111;
      bus.out_ready = 1'b1;
      #3;
      chk("mid_first_ready", 32'(bus.in_ready), 32'b0001);
      drive(4'b1111, 1'b1);
      chk("mid_first_sel",  32'(bus.out_sel),  32'd0);
      chk("mid_first_data", 32'(bus.out_data), 32'hA);

      drive(4'b0000, 1'b1);
      @(negedge clk);
      #5;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
